// File: rtl/zpred_seq.sv
// ============================================================================
// Module  : zpred_seq
// Brief   : Sequencer for the ADPCM zero-predictor taps over a shared
//           FMULT/DELAYPREDIC datapath (load, issue, update per tap, done).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zpred_seq #(
    parameter int NTAPS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] RATE,
    input  logic       TR,
    input  logic       mult_ack,
    output logic       busy,
    output logic [2:0] tap_sel,
    output logic       dq_sel,
    output logic       mult_req,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       upd_en,
    output logic       coef_clr,
    output logic [1:0] rate_q,
    output logic       done,
    output logic       overrun
);

    localparam logic [2:0] C_LAST_TAP = 3'(NTAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ISSUE  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       r_tr_q;
    logic [1:0] r_rate_q;
    logic       r_busy;
    logic [2:0] r_tap_sel;
    logic       r_dq_sel;
    logic       r_mult_req;
    logic       r_acc_clr;
    logic       r_upd_en;
    logic       r_coef_clr;
    logic       r_done;
    logic       r_overrun;

    logic       w_in_issue;

    assign w_in_issue = (r_state == S_ISSUE);

    // Outputs for the next cycle are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_tr_q     <= 1'b0;
            r_rate_q   <= 2'd0;
            r_busy     <= 1'b0;
            r_tap_sel  <= 3'd0;
            r_dq_sel   <= 1'b0;
            r_mult_req <= 1'b0;
            r_acc_clr  <= 1'b0;
            r_upd_en   <= 1'b0;
            r_coef_clr <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_acc_clr  <= 1'b0;
            r_upd_en   <= 1'b0;
            r_coef_clr <= 1'b0;
            r_done     <= 1'b0;

            // Any start outside IDLE (DONE included) is a dropped sample.
            if (start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_rate_q   <= RATE;
                        r_tr_q     <= TR;
                        r_cnt      <= 3'd0;
                        r_busy     <= 1'b1;
                        r_acc_clr  <= 1'b1;
                        r_tap_sel  <= 3'd0;
                        r_dq_sel   <= 1'b0;
                        r_mult_req <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_ISSUE;
                    r_cnt      <= 3'd0;
                    r_mult_req <= 1'b1;
                    r_tap_sel  <= 3'd0;
                    r_dq_sel   <= 1'b1;
                end
                S_ISSUE: begin
                    if (mult_ack) begin
                        r_state    <= S_UPDATE;
                        r_mult_req <= 1'b0;
                        r_upd_en   <= ~r_tr_q;
                        r_coef_clr <= r_tr_q;
                    end
                end
                S_UPDATE: begin
                    if (r_cnt == C_LAST_TAP) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_tap_sel <= 3'd0;
                        r_dq_sel  <= 1'b0;
                    end else begin
                        r_state    <= S_ISSUE;
                        r_cnt      <= r_cnt + 3'd1;
                        r_mult_req <= 1'b1;
                        r_tap_sel  <= r_cnt + 3'd1;
                        r_dq_sel   <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_cnt     <= 3'd0;
                    r_tap_sel <= 3'd0;
                    r_dq_sel  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_cnt      <= 3'd0;
                    r_tap_sel  <= 3'd0;
                    r_dq_sel   <= 1'b0;
                    r_mult_req <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign tap_sel  = r_tap_sel;
    assign dq_sel   = r_dq_sel;
    assign mult_req = r_mult_req;
    assign acc_clr  = r_acc_clr;
    assign acc_en   = w_in_issue & mult_ack;
    assign upd_en   = r_upd_en;
    assign coef_clr = r_coef_clr;
    assign rate_q   = r_rate_q;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_zpred_seq.sv
// ============================================================================
// Module  : tb_zpred_seq
// Brief   : Table-driven cycle-by-cycle bench for zpred_seq (NTAPS=6).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zpred_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] RATE;
    logic       TR;
    logic       mult_ack;
    logic       busy;
    logic [2:0] tap_sel;
    logic       dq_sel;
    logic       mult_req;
    logic       acc_clr;
    logic       acc_en;
    logic       upd_en;
    logic       coef_clr;
    logic [1:0] rate_q;
    logic       done;
    logic       overrun;

    zpred_seq #(.NTAPS(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .RATE     (RATE),
        .TR       (TR),
        .mult_ack (mult_ack),
        .busy     (busy),
        .tap_sel  (tap_sel),
        .dq_sel   (dq_sel),
        .mult_req (mult_req),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .upd_en   (upd_en),
        .coef_clr (coef_clr),
        .rate_q   (rate_q),
        .done     (done),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         scen;
        int         cyc;
        logic       rst;
        logic       start;
        logic [1:0] rate;
        logic       tr;
        logic       ack;
        logic       busy;
        logic [2:0] tap;
        logic       dq;
        logic       req;
        logic       clr;
        logic       acc;
        logic       upd;
        logic       cclr;
        logic [1:0] rq;
        logic       done;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];
    int   n_tests;
    int   n_fail;

    task automatic check(input logic ok, input string what);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s", what);
        end
    endtask

    // Expected cycle c of one sequence started at cycle 0 with mult_ack tied high.
    function automatic vec_t nominal(int c, logic tr, logic [1:0] rate, logic [1:0] prev);
        vec_t v;
        int   k;
        v       = '{default: '0};
        v.start = (c == 0);
        v.rate  = rate;
        v.tr    = tr;
        v.ack   = 1'b1;
        v.rq    = (c == 0) ? prev : rate;
        if (c == 1) begin
            v.busy = 1'b1;
            v.clr  = 1'b1;
        end else if (c >= 2 && c <= 13) begin
            k      = (c - 2) / 2;
            v.busy = 1'b1;
            v.tap  = 3'(k);
            v.dq   = (k == 0);
            if (c % 2 == 0) begin
                v.req = 1'b1;
                v.acc = 1'b1;
            end else begin
                v.upd  = ~tr;
                v.cclr = tr;
            end
        end else if (c == 14) begin
            v.busy = 1'b1;
            v.done = 1'b1;
        end
        return v;
    endfunction

    function automatic vec_t tag(vec_t vin, int s, int c);
        vec_t v;
        v      = vin;
        v.scen = s;
        v.cyc  = c;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   b;
        int   waited;
        logic got_done;
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        RATE     = 2'd0;
        TR       = 1'b0;
        mult_ack = 1'b0;

        // Scenario 0: start during reset is ignored; reset values.
        v = '{default: '0}; v.rst = 1'b1; v.start = 1'b1; v.rate = 2'd3; v.tr = 1'b1;
        tbl.push_back(tag(v, 0, 0));
        v = '{default: '0}; v.ack = 1'b1;
        tbl.push_back(tag(v, 0, 1));

        // Scenario 1: RATE=2, TR=0, normal updates.
        for (int c = 0; c <= 15; c++) tbl.push_back(tag(nominal(c, 1'b0, 2'd2, 2'd0), 1, c));

        // Scenario 2: TR=1 -> coefficient zeroing instead of updates.
        for (int c = 0; c <= 15; c++) tbl.push_back(tag(nominal(c, 1'b1, 2'd1, 2'd2), 2, c));

        // Scenario 3: four-cycle multiplier stall on tap 2.
        for (int c = 0; c <= 19; c++) begin
            b = (c < 6) ? c : ((c < 10) ? 6 : c - 4);
            v = nominal(b, 1'b0, 2'd3, 2'd1);
            v.start = (c == 0);
            if (c >= 6 && c <= 9) begin
                v.ack = 1'b0;
                v.acc = 1'b0;
            end
            tbl.push_back(tag(v, 3, c));
        end

        // Scenario 4: starts at cycles 7 and 14 are dropped and flag overrun.
        for (int c = 0; c <= 17; c++) begin
            v = nominal(c, 1'b0, 2'd2, 2'd3);
            if (c == 7 || c == 14) begin
                v.start = 1'b1;
                v.rate  = 2'd3;
                v.tr    = 1'b1;
            end
            v.ovr = (c >= 8);
            v.rst = (c == 17);
            tbl.push_back(tag(v, 4, c));
        end

        // Scenario 5: reset mid-sequence at cycle 8, restart at cycle 10.
        for (int c = 0; c <= 25; c++) begin
            if (c <= 8) begin
                v = nominal(c, 1'b0, 2'd1, 2'd0);
                v.rst = (c == 8);
            end else if (c == 9) begin
                v = '{default: '0}; v.ack = 1'b1;
            end else begin
                v = nominal(c - 10, 1'b0, 2'd2, 2'd0);
            end
            tbl.push_back(tag(v, 5, c));
        end

        // Scenario 6: back-to-back start right after done.
        for (int c = 0; c <= 30; c++) begin
            if (c <= 14) v = nominal(c, 1'b1, 2'd3, 2'd2);
            else         v = nominal(c - 15, 1'b0, 2'd1, 2'd3);
            tbl.push_back(tag(v, 6, c));
        end

        repeat (2) @(posedge clk);
        #1;

        check({busy, tap_sel, dq_sel, mult_req, acc_clr, acc_en, upd_en, coef_clr, rate_q, done, overrun} === '0,
              "reset_state: outputs not all zero while reset held");

        foreach (tbl[i]) begin
            reset    = tbl[i].rst;
            start    = tbl[i].start;
            RATE     = tbl[i].rate;
            TR       = tbl[i].tr;
            mult_ack = tbl[i].ack;
            #1;
            n_tests++;
            if ({busy, tap_sel, dq_sel, mult_req, acc_clr, acc_en, upd_en, coef_clr, rate_q, done, overrun} !==
                {tbl[i].busy, tbl[i].tap, tbl[i].dq, tbl[i].req, tbl[i].clr, tbl[i].acc,
                 tbl[i].upd, tbl[i].cclr, tbl[i].rq, tbl[i].done, tbl[i].ovr}) begin
                n_fail++;
                $display("FAIL scen%0d_cyc%0d: got busy=%b tap=%0d dq=%b req=%b clr=%b acc=%b upd=%b cclr=%b rq=%0d done=%b ovr=%b; want busy=%b tap=%0d dq=%b req=%b clr=%b acc=%b upd=%b cclr=%b rq=%0d done=%b ovr=%b",
                         tbl[i].scen, tbl[i].cyc,
                         busy, tap_sel, dq_sel, mult_req, acc_clr, acc_en, upd_en, coef_clr, rate_q, done, overrun,
                         tbl[i].busy, tbl[i].tap, tbl[i].dq, tbl[i].req, tbl[i].clr, tbl[i].acc,
                         tbl[i].upd, tbl[i].cclr, tbl[i].rq, tbl[i].done, tbl[i].ovr);
            end
            @(posedge clk);
            #1;
        end

        // Bounded wait for done on a fresh sequence; expiry is a failure.
        reset    = 1'b0;
        start    = 1'b1;
        RATE     = 2'd1;
        TR       = 1'b0;
        mult_ack = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        waited   = 1;
        got_done = done;
        while (!got_done && waited < 30) begin
            @(posedge clk);
            #1;
            waited++;
            got_done = done;
        end
        check(got_done, "expired_wait: done not seen within 30 cycles");
        check(waited == 14, $sformatf("expired_wait: done at cycle %0d, want 14", waited));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/zpred_seq.md
ZPRED_SEQ -- requirements
Module: zpred_seq

Interface
REQ-001 Parameter NTAPS, default 6, number of zero-predictor taps sequenced per sample (legal 1..7).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse: new sample DQ valid, begin tap sequence.
REQ-005 RATE  input  2  ADPCM rate code, sampled with start.
REQ-006 TR  input  1  transition-detected flag, sampled with start.
REQ-007 mult_ack  input  1  shared FMULT/tap datapath accepted current tap's operands.
REQ-008 busy  output  1  high from cycle after accepted start until DONE cycle inclusive.
REQ-009 tap_sel  output  3  index of tap currently driven onto shared DELAYPREDIC datapath.
REQ-010 dq_sel  output  1  1 = feed new DQ (tap 0), 0 = feed previous tap's DQN.
REQ-011 mult_req  output  1  request to shared multiplier for tap_sel.
REQ-012 acc_clr  output  1  clear partial-sum accumulator.
REQ-013 acc_en  output  1  add current tap product into accumulator.
REQ-014 upd_en  output  1  strobe coefficient/delay update of tap_sel (normal update).
REQ-015 coef_clr  output  1  strobe coefficient zeroing of tap_sel (trigger on TR).
REQ-016 rate_q  output  2  RATE latched at start, stable for whole sequence.
REQ-017 done  output  1  one-cycle pulse: all NTAPS taps processed.
REQ-018 overrun  output  1  sticky: start arrived while busy.

Function
REQ-019 FSM states IDLE, LOAD, ISSUE, UPDATE, DONE; 3-bit tap counter.
REQ-020 IDLE: start=1 -> LOAD next cycle; RATE->rate_q, TR->tr_q latched on same edge; otherwise stay.
REQ-021 LOAD (1 cycle): acc_clr=1, tap counter=0; -> ISSUE.
REQ-022 ISSUE: mult_req=1, tap_sel=counter, dq_sel=(counter==0); held until mult_ack=1; stall indefinitely while mult_ack=0.
REQ-023 ISSUE with mult_ack=1: acc_en=1 that same cycle; -> UPDATE.
REQ-024 UPDATE (1 cycle): tr_q=0 -> upd_en=1, coef_clr=0; tr_q=1 -> coef_clr=1, upd_en=0; tap_sel unchanged from ISSUE.
REQ-025 UPDATE: counter==NTAPS-1 -> DONE; else counter+1 -> ISSUE.
REQ-026 DONE (1 cycle): done=1, busy=1; -> IDLE; start in DONE cycle is treated as busy (ignored, overrun set).
REQ-027 Latency with mult_ack tied 1: start at cycle 0 -> ISSUE tap k at cycle 2+2k, UPDATE at 3+2k, done at cycle 2*NTAPS+2 (14 for NTAPS=6).
REQ-028 mult_ack outside ISSUE is ignored.
REQ-029 start while busy: no state change, rate_q/tr_q unchanged, overrun=1 from next cycle until reset.
REQ-030 upd_en, coef_clr, acc_en, acc_clr, done mutually exclusive single-cycle strobes; never two in same cycle.
REQ-031 Outputs are registered state decodes except acc_en (combinational on mult_ack in ISSUE).
REQ-032 IDLE: tap_sel=0, dq_sel=0, all strobes 0.

Reset
REQ-033 reset=1 at a clock edge -> IDLE next cycle regardless of state, including mid-sequence; aborted sequence emits no done.
REQ-034 Reset values: busy=0, tap_sel=0, dq_sel=0, mult_req=0, acc_clr=0, acc_en=0, upd_en=0, coef_clr=0, rate_q=0, done=0, overrun=0, counter=0, tr_q=0.
REQ-035 start coincident with reset is ignored.

Verification
REQ-036 mult_ack=1, start with RATE=2, TR=0 -> acc_clr @1, upd_en @3,5,...,13 with tap_sel 0..5, dq_sel=1 only @2-3, done @14, rate_q=2 @1-14.
REQ-037 TR=1 at start -> coef_clr pulses @3,5,...,13, upd_en never asserted, done @14.
REQ-038 mult_ack=0 for 4 cycles on tap 2 -> mult_req held with tap_sel=2, no acc_en until ack, done delayed to cycle 18.
REQ-039 Second start at cycle 7 and at cycle 14 -> both ignored, overrun=1 from cycle 8, sequence completes at 14 unaffected.
REQ-040 reset at cycle 8 mid-sequence -> all outputs 0 @9, no done; new start @10 -> done @24.
REQ-041 Back-to-back: start @15 after done @14 -> accepted, done @29, overrun stays 0.
